// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch: PC, one-at-a-time imem requests and the IF/ID register.
// Ports: clk/reset_n, imem req/addr/valid/rdata, stall/flush, branch inputs, instr/instr_pc/instr_valid.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic        uncond_br,
  input  logic [63:0] br_pc,
  input  logic [18:0] cond_addr19,
  input  logic [25:0] br_addr26,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q;
  logic [63:0] instr_pc_q;
  logic        instr_valid_q;

  logic        load;
  logic [31:0] load_word;
  logic [63:0] offset;
  logic [63:0] target;
  logic [63:0] pc_inc;

  assign offset = uncond_br
    ? {{38{br_addr26[25]}}, br_addr26}
    : {{45{cond_addr19[18]}}, cond_addr19};
  assign target = br_pc + (offset << 2);
  assign pc_inc = pc_q + 64'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    load      = 1'b0;
    load_word = imem_rdata;
    unique case (state_q)
      S_IDLE: state_d = S_ISSUE;
      S_ISSUE: begin
        if (br_taken) begin
          pc_d    = target;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (br_taken) begin
          pc_d    = target;
          state_d = imem_valid ? S_ISSUE : S_DROP;
        end else if (imem_valid) begin
          if (stall && instr_valid_q) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            load    = 1'b1;
            pc_d    = pc_inc;
            state_d = S_ISSUE;
          end
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          pc_d    = target;
          state_d = S_ISSUE;
        end else if (!stall) begin
          load      = 1'b1;
          load_word = skid_q;
          pc_d      = pc_inc;
          state_d   = S_ISSUE;
        end
      end
      S_DROP: begin
        // A late redirect retargets the PC; the stale
        // response still has to be swallowed first.
        if (br_taken) pc_d = target;
        if (imem_valid) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      skid_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  // A load while stalled only happens into an empty
  // register, so it never overwrites a held instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q       <= 32'h0;
      instr_pc_q    <= 64'h0;
      instr_valid_q <= 1'b0;
    end else if (flush || br_taken) begin
      instr_valid_q <= 1'b0;
    end else if (load) begin
      instr_q       <= load_word;
      instr_pc_q    <= pc_q;
      instr_valid_q <= 1'b1;
    end else if (!stall) begin
      instr_valid_q <= 1'b0;
    end
  end

  assign imem_req    = (state_q == S_ISSUE);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule
